// File: rtl/cavlc_bitstream_packer.sv
// cavlc_bitstream_packer
// Packs the five variable-length CAVLC fields of one 4x4 block MSB-first
// into a left-aligned accumulator. Full OUT_W-bit words leave on a
// valid/ready stream. A flush zero-pads the tail to a word boundary.
// ACC_W must be at least OUT_W + 64, so that the widest field (50 bits)
// always fits once a word has been drained.
// Optional build macro: CAVLC_BIS_STAT_EN adds the bit_count_o and
// blk_count_o statistics outputs.

module cavlc_bitstream_packer #(
   parameter int ACC_W = 96,
   parameter int OUT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cavlc_enc_valid,
   output logic              cavlc_bis_ready,
   input  logic [15:0]       coeff_token_code,
   input  logic [4:0]        coeff_token_bit,
   input  logic              coeff_token_valid,
   input  logic [2:0]        trailingones_code,
   input  logic [3:0]        trailingones_bit,
   input  logic              trailingones_valid,
   input  logic [49:0]       levelcode_code,
   input  logic [5:0]        levelcode_bit,
   input  logic              levelcode_valid,
   input  logic [8:0]        totalzero_code,
   input  logic [3:0]        totalzero_bit,
   input  logic              totalzero_valid,
   input  logic [24:0]       runbefore_code,
   input  logic [4:0]        runbefore_bit,
   input  logic              runbefore_valid,
   input  logic              flush_i,
   output logic [OUT_W-1:0]  word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic              word_last_o,
   output logic              flush_done_o
`ifdef CAVLC_BIS_STAT_EN
   ,
   output logic [31:0]       bit_count_o,
   output logic [15:0]       blk_count_o
`endif
);

   localparam int FILL_W  = $clog2(ACC_W) + 1;
   localparam int SUM_W   = FILL_W + 1;
   localparam int FIELD_W = 50;
   localparam int LEN_W   = 6;
   localparam logic [FILL_W-1:0] ACC_W_F = FILL_W'(ACC_W);
   localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CT,
      S_T1,
      S_LV,
      S_TZ,
      S_RB,
      S_FLUSH
   } state_t;

   state_t               state, state_nxt;
   logic [ACC_W-1:0]     acc, acc_nxt, acc_shift, placed;
   logic [FILL_W-1:0]    fill, fill_nxt, fill_shift, place_sh;
   logic [SUM_W-1:0]     fill_sum;
   logic [FIELD_W-1:0]   fld_code, code_masked;
   logic [LEN_W-1:0]     fld_len;
   logic                 in_field, fits, do_append, emit, capture;

   // Latched copy of one encoded block
   logic [15:0] ct_code_q;
   logic [4:0]  ct_bit_q;
   logic        ct_valid_q;
   logic [2:0]  t1_code_q;
   logic [3:0]  t1_bit_q;
   logic        t1_valid_q;
   logic [49:0] lv_code_q;
   logic [5:0]  lv_bit_q;
   logic        lv_valid_q;
   logic [8:0]  tz_code_q;
   logic [3:0]  tz_bit_q;
   logic        tz_valid_q;
   logic [24:0] rb_code_q;
   logic [4:0]  rb_bit_q;
   logic        rb_valid_q;

   // Lengths beyond the width of a field's code port are capped there
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

   assign capture = (state == S_IDLE) && cavlc_enc_valid;

   // Capture all field inputs when a block is accepted
   // NOTE: these data registers have no reset; nothing reads them before a capture loads them.
   always_ff @(posedge clk) begin
      if (capture) begin
         ct_code_q  <= coeff_token_code;
         ct_bit_q   <= coeff_token_bit;
         ct_valid_q <= coeff_token_valid;
         t1_code_q  <= trailingones_code;
         t1_bit_q   <= trailingones_bit;
         t1_valid_q <= trailingones_valid;
         lv_code_q  <= levelcode_code;
         lv_bit_q   <= levelcode_bit;
         lv_valid_q <= levelcode_valid;
         tz_code_q  <= totalzero_code;
         tz_bit_q   <= totalzero_bit;
         tz_valid_q <= totalzero_valid;
         rb_code_q  <= runbefore_code;
         rb_bit_q   <= runbefore_bit;
         rb_valid_q <= runbefore_valid;
      end
   end

   // Select the field that the current append state works on
   // NOTE: every always_comb output gets a default first so that no path can infer a latch.
   always_comb begin
      fld_code = '0;
      fld_len  = '0;
      unique case (state)
         S_CT: if (ct_valid_q) begin
            fld_code = FIELD_W'(ct_code_q);
            fld_len  = clamp_len(LEN_W'(ct_bit_q), 6'd16);
         end
         S_T1: if (t1_valid_q) begin
            fld_code = FIELD_W'(t1_code_q);
            fld_len  = clamp_len(LEN_W'(t1_bit_q), 6'd3);
         end
         S_LV: if (lv_valid_q) begin
            fld_code = lv_code_q;
            fld_len  = clamp_len(lv_bit_q, 6'd50);
         end
         S_TZ: if (tz_valid_q) begin
            fld_code = FIELD_W'(tz_code_q);
            fld_len  = clamp_len(LEN_W'(tz_bit_q), 6'd9);
         end
         S_RB: if (rb_valid_q) begin
            fld_code = FIELD_W'(rb_code_q);
            fld_len  = clamp_len(LEN_W'(rb_bit_q), 6'd25);
         end
         default: ;
      endcase
   end

   // Drop code bits above the field length
   assign code_masked = fld_code & ((FIELD_W'(1) << fld_len) - FIELD_W'(1));

   assign in_field = state inside {S_CT, S_T1, S_LV, S_TZ, S_RB};

   // Output word view; in FLUSH any nonzero fill is a (zero-padded) word
   assign word_o       = acc[ACC_W-1 -: OUT_W];
   assign word_valid_o = (state == S_FLUSH) ? (fill != '0) : (fill >= OUT_W_F);
   assign word_last_o  = (state == S_FLUSH) && (fill != '0) && (fill <= OUT_W_F);
   assign flush_done_o = (state == S_FLUSH) && (fill == '0);
   assign cavlc_bis_ready = (state == S_IDLE);
   assign emit = word_valid_o && word_ready_i;

   // Drain a word first, then place the field behind the post-drain fill
   // NOTE: combinational blocks use blocking '=', clocked state uses non-blocking '<='.
   always_comb begin
      acc_shift  = acc;
      fill_shift = fill;
      if (emit) begin
         acc_shift  = acc << OUT_W;
         fill_shift = (fill > OUT_W_F) ? (fill - OUT_W_F) : '0;
      end
      fill_sum  = {1'b0, fill_shift} + SUM_W'(fld_len);
      fits      = (fill_sum <= SUM_W'(ACC_W));
      do_append = in_field && fits;
      place_sh  = ACC_W_F - fill_shift - FILL_W'(fld_len);
      placed    = ACC_W'(code_masked) << place_sh;
      acc_nxt   = acc_shift;
      fill_nxt  = fill_shift;
      if (do_append) begin
         acc_nxt  = acc_shift | placed;
         fill_nxt = fill_sum[FILL_W-1:0];
      end
   end

   // Next-state logic: append states advance only once their field fits
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (cavlc_enc_valid)  state_nxt = S_CT;
            else if (flush_i)     state_nxt = S_FLUSH;
         end
         S_CT:    if (fits) state_nxt = S_T1;
         S_T1:    if (fits) state_nxt = S_LV;
         S_LV:    if (fits) state_nxt = S_TZ;
         S_TZ:    if (fits) state_nxt = S_RB;
         S_RB:    if (fits) state_nxt = S_IDLE;
         S_FLUSH: if (fill == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, accumulator and fill registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         acc   <= '0;
         fill  <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         fill  <= fill_nxt;
      end
   end

`ifdef CAVLC_BIS_STAT_EN
   logic [32:0] bit_sum;

   assign bit_sum = {1'b0, bit_count_o} + 33'(fld_len);

   // Appended-bit counter (saturating) and captured-block counter (wrapping)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_count_o <= '0;
         blk_count_o <= '0;
      end else begin
         if (do_append)
            bit_count_o <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
         if (capture)
            blk_count_o <= blk_count_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
// Self-checking bench for cavlc_bitstream_packer. A bit-level reference
// model turns every driven block into expected words on a queue; a monitor
// pops and compares them as the DUT hands words over.
// Build with +define+CAVLC_BIS_STAT_EN to also check the statistics outputs.

module tb_cavlc_bitstream_packer;

   localparam int ACC_W = 96;
   localparam int OUT_W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        cavlc_enc_valid;
   logic        cavlc_bis_ready;
   logic [15:0] coeff_token_code;
   logic [4:0]  coeff_token_bit;
   logic        coeff_token_valid;
   logic [2:0]  trailingones_code;
   logic [3:0]  trailingones_bit;
   logic        trailingones_valid;
   logic [49:0] levelcode_code;
   logic [5:0]  levelcode_bit;
   logic        levelcode_valid;
   logic [8:0]  totalzero_code;
   logic [3:0]  totalzero_bit;
   logic        totalzero_valid;
   logic [24:0] runbefore_code;
   logic [4:0]  runbefore_bit;
   logic        runbefore_valid;
   logic        flush_i;
   logic [31:0] word_o;
   logic        word_valid_o;
   logic        word_ready_i;
   logic        word_last_o;
   logic        flush_done_o;
`ifdef CAVLC_BIS_STAT_EN
   logic [31:0] bit_count_o;
   logic [15:0] blk_count_o;
`endif

   typedef struct packed {
      logic [15:0] ct_c; logic [4:0] ct_b; logic ct_v;
      logic [2:0]  t1_c; logic [3:0] t1_b; logic t1_v;
      logic [49:0] lv_c; logic [5:0] lv_b; logic lv_v;
      logic [8:0]  tz_c; logic [3:0] tz_b; logic tz_v;
      logic [24:0] rb_c; logic [4:0] rb_b; logic rb_v;
   } blk_t;

   typedef struct packed {
      logic [31:0] word;
      logic        last;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   words_seen = 0;
   logic any_valid = 1'b0;
   logic [31:0] last_word = '0;
   bit   model_bits[$];
   exp_t exp_q[$];

   cavlc_bitstream_packer #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .cavlc_enc_valid    (cavlc_enc_valid),
      .cavlc_bis_ready    (cavlc_bis_ready),
      .coeff_token_code   (coeff_token_code),
      .coeff_token_bit    (coeff_token_bit),
      .coeff_token_valid  (coeff_token_valid),
      .trailingones_code  (trailingones_code),
      .trailingones_bit   (trailingones_bit),
      .trailingones_valid (trailingones_valid),
      .levelcode_code     (levelcode_code),
      .levelcode_bit      (levelcode_bit),
      .levelcode_valid    (levelcode_valid),
      .totalzero_code     (totalzero_code),
      .totalzero_bit      (totalzero_bit),
      .totalzero_valid    (totalzero_valid),
      .runbefore_code     (runbefore_code),
      .runbefore_bit      (runbefore_bit),
      .runbefore_valid    (runbefore_valid),
      .flush_i            (flush_i),
      .word_o             (word_o),
      .word_valid_o       (word_valid_o),
      .word_ready_i       (word_ready_i),
      .word_last_o        (word_last_o),
      .flush_done_o       (flush_done_o)
`ifdef CAVLC_BIS_STAT_EN
      ,
      .bit_count_o        (bit_count_o),
      .blk_count_o        (blk_count_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference model: a plain bit queue, MSB of each field first
   task automatic model_add(input logic [49:0] code, input int len);
      for (int i = len - 1; i >= 0; i--) model_bits.push_back(code[i]);
   endtask

   task automatic model_pop_word(input logic last);
      logic [31:0] w;
      w = '0;
      for (int i = 31; i >= 0; i--)
         if (model_bits.size() != 0) w[i] = model_bits.pop_front();
      exp_q.push_back('{word: w, last: last});
   endtask

   task automatic model_block(input blk_t b);
      if (b.ct_v) model_add(50'(b.ct_c), int'(b.ct_b));
      if (b.t1_v) model_add(50'(b.t1_c), int'(b.t1_b));
      if (b.lv_v) model_add(b.lv_c, int'(b.lv_b));
      if (b.tz_v) model_add(50'(b.tz_c), int'(b.tz_b));
      if (b.rb_v) model_add(50'(b.rb_c), int'(b.rb_b));
      while (model_bits.size() >= 32) model_pop_word(1'b0);
   endtask

   task automatic model_flush();
      if (model_bits.size() != 0) model_pop_word(1'b1);
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (flush_done_o) done_cnt++;
      if (word_valid_o) any_valid = 1'b1;
      if (rst && word_valid_o && word_ready_i) begin
         check("exp_avail", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("word", 64'(word_o), 64'(e.word));
            check("word_last", 64'(word_last_o), 64'(e.last));
         end
         last_word = word_o;
         words_seen++;
      end
   end

   task automatic wait_ready(input int budget);
      int n;
      n = 0;
      while (!cavlc_bis_ready && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cavlc_bis_ready) check("ready_timeout", 64'(cavlc_bis_ready), 64'd1);
   endtask

   task automatic send_block(input blk_t b);
      wait_ready(60);
      coeff_token_code   = b.ct_c; coeff_token_bit  = b.ct_b; coeff_token_valid  = b.ct_v;
      trailingones_code  = b.t1_c; trailingones_bit = b.t1_b; trailingones_valid = b.t1_v;
      levelcode_code     = b.lv_c; levelcode_bit    = b.lv_b; levelcode_valid    = b.lv_v;
      totalzero_code     = b.tz_c; totalzero_bit    = b.tz_b; totalzero_valid    = b.tz_v;
      runbefore_code     = b.rb_c; runbefore_bit    = b.rb_b; runbefore_valid    = b.rb_v;
      cavlc_enc_valid = 1'b1;
      @(posedge clk); #1;
      cavlc_enc_valid = 1'b0;
      model_block(b);
   endtask

   task automatic do_flush();
      int d0, n;
      wait_ready(60);
      d0 = done_cnt;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      model_flush();
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("flush_done_pulses", 64'(done_cnt - d0), 64'd1);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic blk_t lv_only(input logic [49:0] c, input logic [5:0] b);
      blk_t r;
      r = '0;
      r.lv_c = c; r.lv_b = b; r.lv_v = 1'b1;
      return r;
   endfunction

   initial begin
      blk_t s1, none_b;
      int   w0, cnt;

      s1 = '0;
      s1.ct_c = 16'h0005; s1.ct_b = 5'd6; s1.ct_v = 1'b1;
      s1.t1_c = 3'h3;     s1.t1_b = 4'd2; s1.t1_v = 1'b1;
      s1.lv_c = 50'h1;    s1.lv_b = 6'd1; s1.lv_v = 1'b1;
      s1.tz_c = 9'h003;   s1.tz_b = 4'd3; s1.tz_v = 1'b1;
      s1.rb_c = 25'h2;    s1.rb_b = 5'd2; s1.rb_v = 1'b1;
      // Nonzero codes with every valid low: nothing may be appended
      none_b = s1;
      none_b.ct_v = 1'b0; none_b.t1_v = 1'b0; none_b.lv_v = 1'b0;
      none_b.tz_v = 1'b0; none_b.rb_v = 1'b0;

      rst = 1'b0;
      cavlc_enc_valid = 1'b0;
      flush_i = 1'b0;
      word_ready_i = 1'b1;
      coeff_token_code = '0; coeff_token_bit = '0; coeff_token_valid = 1'b0;
      trailingones_code = '0; trailingones_bit = '0; trailingones_valid = 1'b0;
      levelcode_code = '0; levelcode_bit = '0; levelcode_valid = 1'b0;
      totalzero_code = '0; totalzero_bit = '0; totalzero_valid = 1'b0;
      runbefore_code = '0; runbefore_bit = '0; runbefore_valid = 1'b0;

      // Reset values
      #1;
      check("rst_ready", 64'(cavlc_bis_ready), 64'd1);
      check("rst_valid", 64'(word_valid_o), 64'd0);
      check("rst_word", 64'(word_o), 64'd0);
      check("rst_last", 64'(word_last_o), 64'd0);
      check("rst_done", 64'(flush_done_o), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Scenario 1: single block then flush -> 0x17B80000 (last)
      w0 = words_seen;
      send_block(s1);
      do_flush();
      check("s1_words", 64'(words_seen - w0), 64'd1);
      check("s1_word_value", 64'(last_word), 64'h17B80000);

      // Scenario 2: all fields absent; ready back 6 cycles after capture
      any_valid = 1'b0;
      w0 = words_seen;
      wait_ready(60);
      coeff_token_valid = 1'b0; trailingones_valid = 1'b0; levelcode_valid = 1'b0;
      totalzero_valid = 1'b0; runbefore_valid = 1'b0;
      coeff_token_code = none_b.ct_c; coeff_token_bit = none_b.ct_b;
      levelcode_code = 50'h3FFFF; levelcode_bit = 6'd18;
      cavlc_enc_valid = 1'b1;
      @(posedge clk); #1;
      cavlc_enc_valid = 1'b0;
      model_block(none_b);
      cnt = 1;
      while (!cavlc_bis_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("s2_ready_latency", 64'(cnt), 64'd6);
      do_flush();
      check("s2_no_word", 64'(words_seen - w0), 64'd0);
      check("s2_valid_never", 64'(any_valid), 64'd0);

      // Scenario 3: two 20-bit blocks; first word appears during block two
      w0 = words_seen;
      send_block(lv_only(50'hFFFFF, 6'd20));
      wait_ready(60);
      send_block(lv_only(50'hFFFFF, 6'd20));
      wait_ready(60);
      check("s3_word_in_block2", 64'(words_seen - w0), 64'd1);
      check("s3_word1", 64'(last_word), 64'hFFFFFFFF);
      do_flush();
      check("s3_flush_word", 64'(last_word), 64'hFF000000);

      // Scenario 4: consumer stalled, three 50-bit all-ones blocks
      w0 = words_seen;
      word_ready_i = 1'b0;
      send_block(lv_only({50{1'b1}}, 6'd50));
      wait_ready(60);
      send_block(lv_only({50{1'b1}}, 6'd50));
      repeat (10) @(posedge clk);
      #1;
      check("s4_stall_ready", 64'(cavlc_bis_ready), 64'd0);
      check("s4_stall_valid", 64'(word_valid_o), 64'd1);
      check("s4_stall_word", 64'(word_o), 64'hFFFFFFFF);
      check("s4_stall_no_hs", 64'(words_seen - w0), 64'd0);
      word_ready_i = 1'b1;
      send_block(lv_only({50{1'b1}}, 6'd50));
      do_flush();
      check("s4_words", 64'(words_seen - w0), 64'd5);
      check("s4_tail", 64'(last_word), 64'hFFFFFC00);

      // Scenario 5: reset while the second block sits in LV with fill=40
      word_ready_i = 1'b0;
      send_block(lv_only(50'h00AB_CDEF_1234, 6'd40));
      wait_ready(60);
      send_block(lv_only(50'h3FF, 6'd10));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("mid_rst_ready", 64'(cavlc_bis_ready), 64'd1);
      check("mid_rst_valid", 64'(word_valid_o), 64'd0);
      check("mid_rst_word", 64'(word_o), 64'd0);
      check("mid_rst_last", 64'(word_last_o), 64'd0);
      check("mid_rst_done", 64'(flush_done_o), 64'd0);
      model_bits.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      word_ready_i = 1'b1;
      w0 = words_seen;
      send_block(s1);
      send_block(lv_only(50'hFFFFF, 6'd20));
      wait_ready(60);
`ifdef CAVLC_BIS_STAT_EN
      check("stat_bits", 64'(bit_count_o), 64'd34);
      check("stat_blocks", 64'(blk_count_o), 64'd2);
`endif
      do_flush();
      check("s5_words", 64'(words_seen - w0), 64'd2);
      check("s5_tail", 64'(last_word), 64'hC0000000);
`ifdef CAVLC_BIS_STAT_EN
      check("stat_bits_no_pad", 64'(bit_count_o), 64'd34);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("final_exp_q", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cavlc_bitstream_packer.md
Name: cavlc_bitstream_packer

Overview:
- Bitstream stage directly downstream of the CAVLC encoder top.
- Accepts one encoded 4x4 block per handshake: coeff_token, trailing-ones signs, level codes, total_zeros and run_before fields, each as a right-aligned code plus bit length.
- Concatenates the fields MSB-first into a left-aligned accumulator and emits 32-bit words on a valid/ready stream.
- Drives cavlc_bis_ready back to the encoder; supports a flush that zero-pads to a word boundary at slice end.

Parameters:
- ACC_W, 96, accumulator width in bits; must be at least OUT_W + 50 + 14.
- OUT_W, 32, output word width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cavlc_enc_valid  in  1  encoded block available
- cavlc_bis_ready  out  1  packer can capture a block
- coeff_token_code  in  16  right-aligned code
- coeff_token_bit  in  5  length 0..16
- coeff_token_valid  in  1  field present
- trailingones_code  in  3  sign bits
- trailingones_bit  in  4  length 0..3
- trailingones_valid  in  1  field present
- levelcode_code  in  50  concatenated level codes
- levelcode_bit  in  6  length 0..50
- levelcode_valid  in  1  field present
- totalzero_code  in  9  code
- totalzero_bit  in  4  length 0..9
- totalzero_valid  in  1  field present
- runbefore_code  in  25  concatenated run_before codes
- runbefore_bit  in  5  length 0..25
- runbefore_valid  in  1  field present
- flush_i  in  1  pad and drain request, sampled in IDLE
- word_o  out  OUT_W  packed word; first bit is in the MSB
- word_valid_o  out  1  word available
- word_ready_i  in  1  consumer accepts word
- word_last_o  out  1  final word of a flush
- flush_done_o  out  1  one-cycle pulse when a flush completes

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; accumulator and fill count cleared.
  - cavlc_bis_ready=1, word_valid_o=0, word_o=0, word_last_o=0, flush_done_o=0.
- FSM states: IDLE, CT, T1, LV, TZ, RB, FLUSH.
- IDLE:
  - cavlc_bis_ready=1.
  - cavlc_enc_valid=1: latch all 15 field inputs, go to CT. This takes priority over flush_i.
  - Else flush_i=1: go to FLUSH.
- CT, T1, LV, TZ, RB:
  - cavlc_bis_ready=0; each state appends its field, then advances in that order; RB returns to IDLE.
  - A field with valid=0 or bit=0 appends nothing and still takes one cycle.
  - Append only when fill+bits <= ACC_W after any same-cycle emit; otherwise stall in the state.
- Append rule:
  - Code bits [bit-1:0] are placed at accumulator positions [ACC_W-1-fill : ACC_W-fill-bit].
  - Code bits above bit-1 are ignored.
- Unstalled latency: capture cycle plus 5 append cycles, so ready reasserts 6 cycles after capture.
- Word emission (all states except FLUSH):
  - word_valid_o = fill >= OUT_W; word_o = accumulator[ACC_W-1 : ACC_W-OUT_W].
  - On word_valid_o && word_ready_i: accumulator shifts left by OUT_W and fill -= OUT_W.
  - Emit and append can occur in the same cycle; the append position uses the post-shift fill.
  - word_o and word_valid_o stay stable while word_ready_i=0.
- FLUSH:
  - Remaining fill is padded with zeros up to a multiple of OUT_W.
  - Words are emitted as above; word_last_o=1 together with the last word.
  - After the last handshake: flush_done_o pulses for one cycle and the FSM returns to IDLE.
  - If fill=0 on entry, no word is emitted and flush_done_o pulses on the next cycle.
- Fill count width is clog2(ACC_W)+1; it never exceeds ACC_W.
- Reset mid-operation discards all buffered bits, including a partly emitted word.

Optional Feature:
- Macro: CAVLC_BIS_STAT_EN.
- Defined, adds two outputs:
  - bit_count_o[31:0]: total appended bits since reset, saturating at 0xFFFFFFFF; padding bits not counted.
  - blk_count_o[15:0]: blocks captured, wrapping.
  - Both reset to 0.
- Undefined: neither port nor its counter logic exists.

Test Plan:
- Single block then flush. Fields: CT 0x05/6, T1 0x3/2, LV 0x1/1, TZ 0x3/3, RB 0x2/2, then flush_i. Required: one word 0x17B80000 with word_last_o=1, then a flush_done_o pulse.
- All five valid=0: cavlc_bis_ready returns 6 cycles after capture; word_valid_o never asserts; a following flush pulses flush_done_o with no word.
- Two blocks of LV 0xFFFFF/20 only: first word 0xFFFFFFFF emitted during the second block; flush gives 0xFF000000 with word_last_o=1.
- word_ready_i held 0 with three blocks of LV 50 bits of all ones: once fill exceeds 46, LV stalls and cavlc_bis_ready stays 0. After word_ready_i rises, words drain in order with no bit lost.
- Assert rst mid-LV with fill=40: all outputs take reset values immediately; a subsequent block plus flush produces only the new block's bits.
- With CAVLC_BIS_STAT_EN: first-scenario block followed by the 20-bit block gives bit_count_o=34 and blk_count_o=2; padding bits are excluded.
